muldiv_iter: RTL and testbench
==============================

// Module: muldiv_iter
// PURPOSE
//   Iterative RV32M multiply/divide unit. Sits beside alu_top in the execute stage.
//   Takes the same A/B operands plus funct3. Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
//   One radix-2 step per clock; a start/busy/done handshake lets the control FSM stall the core until Result is valid.
// PARAMETERS
//   WIDTH  32  operand/result width; iteration count equals WIDTH
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request; sampled at the clock edge
//   A         in   WIDTH  rs1 operand (dividend / multiplicand)
//   B         in   WIDTH  rs2 operand (divisor / multiplier)
//   funct3    in   3      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   busy      out  1      high while an operation is in flight, including the DONE cycle
//   done      out  1      one-cycle pulse: Result valid
//   Result    out  WIDTH  result; held from done until the next accepted start
// BEHAVIOUR
//   Clocking and reset
//   - One clock, clk. Reset rst_n is asynchronous and active-low.
//   - Reset values: busy=0, done=0, Result=0, state=IDLE, counter=0.
//   - Reset asserted mid-operation aborts the operation; no done is produced.
//   FSM: IDLE -> RUN -> FIX -> DONE -> IDLE
//   - IDLE/DONE + start=1: latch the operands.
//     - Signed ops (MULH, MULHSU rs1 only, DIV, REM): latch magnitudes and record the sign flags.
//     - Latch funct3. Set counter=0 and go to RUN.
//   - RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle.
//     - counter increments each cycle; go to FIX when counter == WIDTH-1.
//   - FIX: apply sign correction (two's complement negate), select the low or high product half, or quotient or remainder.
//     - Register Result, go to DONE.
//   - DONE: done=1 for exactly one cycle.
//     - start=1 in DONE is accepted (back-to-back operation); otherwise go to IDLE.
//   - start while in RUN/FIX is ignored. The operation in flight is unaffected.
//   Latency
//   - Fixed for every funct3: start sampled in cycle 0, done high in cycle WIDTH+2 (34 at default).
//   - busy goes high in cycle 1 and falls after the done cycle unless a new start was accepted.
//   Arithmetic
//   - Product is 2*WIDTH bits. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
//   - Quotient truncates toward zero. Remainder takes the sign of the dividend.
//   - Divide by zero: quotient = all ones (-1); remainder = A. Applies to both signed and unsigned.
//   - Signed overflow (A=0x80000000, B=0xFFFFFFFF):
//     - DIV -> 0x80000000
//     - REM -> 0
//   - No exceptions or flags are raised.
// TESTING
//   - MUL A=7, B=-3 (0xFFFFFFFD): done in cycle 34, Result=0xFFFFFFEB; MULHU same operands -> 0x00000006.
//   - MULH A=0x80000000, B=0x80000000 -> 0x40000000; MULHSU A=-1, B=0xFFFFFFFF -> 0xFFFFFFFF.
//   - DIV A=-7, B=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//   - DIVU/REM with B=0, A=0x1234 -> 0xFFFFFFFF / 0x1234; DIV 0x80000000 / -1 -> 0x80000000; REM -> 0.
//   - start pulsed in cycle 5 of a running op -> ignored, single done at cycle 34.
//     - start held in the DONE cycle -> second op starts, done 34 cycles later.
//   - rst_n low at cycle 10 -> busy=0, done=0, Result=0 asynchronously.
//     - After release, a new MUL 3*4 -> 12 with normal latency.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add or restoring
// shift-subtract step per clock, with sign fix-up and a start/busy/done handshake.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       funct3,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_f3;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opb;
  logic             r_neg_p;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_accept;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_amag;
  logic [WIDTH-1:0] w_bmag;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_fix_res;

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 only for MULH, DIV, REM
  assign w_sa   = A[WIDTH-1] && ((funct3 == 3'b001) || (funct3 == 3'b010) ||
                                 (funct3 == 3'b100) || (funct3 == 3'b110));
  assign w_sb   = B[WIDTH-1] && ((funct3 == 3'b001) || (funct3 == 3'b100) ||
                                 (funct3 == 3'b110));
  assign w_amag = w_sa ? (~A + WIDTH'(1)) : A;
  assign w_bmag = w_sb ? (~B + WIDTH'(1)) : B;

  assign w_addend = r_lo[0] ? r_opb : '0;
  assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
  assign w_trial  = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_opb};

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_p ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
  assign w_quo      = r_neg_q ? (~r_lo + WIDTH'(1)) : r_lo;
  assign w_rem      = r_neg_r ? (~r_hi + WIDTH'(1)) : r_hi;

  always_comb begin
    w_fix_res = '0;
    case (r_f3)
      3'b000:                 w_fix_res = w_prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_fix_res = w_quo;
      default:                w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_f3    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opb   <= '0;
      r_neg_p <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      Result  <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (r_f3[2]) begin
            // Restoring divide: keep the difference only when it did not borrow
            if (!w_trial[WIDTH]) begin
              r_hi <= w_trial[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
              r_hi <= {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
              r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          Result  <= w_fix_res;
          r_state <= S_DONE;
        end
        default: begin
          if (w_accept) begin
            r_f3    <= funct3;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= funct3[2] ? w_amag : w_bmag;
            r_opb   <= funct3[2] ? w_bmag : w_amag;
            r_neg_p <= w_sa ^ w_sb;
            // Divide by zero keeps the all-ones quotient regardless of signs
            r_neg_q <= (w_sa ^ w_sb) && (B != '0);
            r_neg_r <= w_sa;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: directed vectors push expected results and
// done cycles; a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  funct3 = '0;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  muldiv_iter #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .funct3 (funct3),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] val;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, Result, e.val);
        check({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit push);
    exp_t e;
    @(negedge clk);
    funct3 = f;
    A      = a;
    B      = b;
    start  = 1'b1;
    if (push) begin
      e.name = nm;
      e.val  = exp;
      e.cyc  = cyc + 34;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_c1"}, {31'b0, busy}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("drain_queue", sb.size(), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    check("busy_idle", {31'b0, busy}, 32'd0);
  endtask

  task automatic op(input string nm, input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp);
    issue(nm, f, a, b, exp, 1'b1);
    drain();
  endtask

  initial begin
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", Result, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    op("mul_7_m3",     3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB);
    op("mulhu_7_m3",   3'b011, 32'd7,         32'hFFFFFFFD, 32'h00000006);
    op("mulh_min_min", 3'b001, 32'h80000000,  32'h80000000, 32'h40000000);
    op("mulhsu_m1",    3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF);
    op("mulh_7_m3",    3'b001, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF);
    op("div_m7_2",     3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD);
    op("rem_m7_2",     3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF);
    op("divu_100_7",   3'b101, 32'd100,       32'd7,        32'd14);
    op("remu_100_7",   3'b111, 32'd100,       32'd7,        32'd2);
    op("divu_by0",     3'b101, 32'h00001234,  32'd0,        32'hFFFFFFFF);
    op("rem_by0",      3'b110, 32'h00001234,  32'd0,        32'h00001234);
    op("div_neg_by0",  3'b100, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFFF);
    op("rem_neg_by0",  3'b110, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFF9);
    op("div_ovf",      3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000);
    op("rem_ovf",      3'b110, 32'h80000000,  32'hFFFFFFFF, 32'h00000000);

    // start pulsed in cycle 5 of a running op must be ignored
    issue("divu_ign", 3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
    repeat (4) @(negedge clk);
    funct3 = 3'b000;
    A      = 32'd9;
    B      = 32'd9;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // back-to-back: second start presented during the DONE cycle
    issue("b2b_mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);
    repeat (32) @(negedge clk);
    issue("b2b_mulhu", 3'b011, 32'd7, 32'hFFFFFFFD, 32'h00000006, 1'b1);
    drain();

    // asynchronous reset at cycle 10 aborts the op with no done
    issue("abort", 3'b000, 32'd5, 32'd6, 32'd30, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_result", Result, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
